unidad_busqueda: RTL

UNIDAD_BUSQUEDA -- requirements
Module: unidad_busqueda

---
 rtl/unidad_busqueda.sv | 119 +++++++++++
 1 files changed

// File: rtl/unidad_busqueda.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a small
// INIT/RUN/HALT controller with branch redirect, stall, flush and a fetch counter.
module unidad_busqueda #(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [5:0]  branch_target,
  input  logic [31:0] instru,
  output logic [5:0]  direinstru,
  output logic [31:0] ifid_instru,
  output logic [5:0]  ifid_pc,
  output logic [5:0]  ifid_pc_next,
  output logic        ifid_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instru;
    logic [5:0]  pc;
    logic [5:0]  pc_next;
    logic        valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '0;

  state_t      r_state, w_state_next;
  logic [5:0]  r_pc, w_pc_next, w_pc_inc;
  ifid_t       r_ifid, w_ifid_next;
  logic [15:0] r_fetch_count, w_fetch_count_next;
  logic        r_halted;
  logic        w_load_fetch;

  // 6-bit add wraps 63 -> 0 on its own.
  assign w_pc_inc = r_pc + 6'd1;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ifid_next  = r_ifid;
    w_load_fetch = 1'b0;

    case (r_state)
      ST_INIT: begin
        w_pc_next    = 6'd0;
        w_ifid_next  = BUBBLE;
        w_state_next = ST_RUN;
      end
      default: begin
        if (branch_taken) begin
          w_pc_next    = branch_target;
          w_ifid_next  = BUBBLE;
          w_state_next = ST_RUN;
        end else if (stall) begin
          if (flush) w_ifid_next = BUBBLE;
        end else if (r_state == ST_HALT) begin
          w_ifid_next = BUBBLE;
        end else if (flush) begin
          w_pc_next   = w_pc_inc;
          w_ifid_next = BUBBLE;
        end else begin
          w_ifid_next.instru  = instru;
          w_ifid_next.pc      = r_pc;
          w_ifid_next.pc_next = w_pc_inc;
          w_ifid_next.valid   = 1'b1;
          w_load_fetch        = 1'b1;
          // A halt word is latched as valid, but the PC parks on it.
          if (instru[31:26] == HALT_OP) w_state_next = ST_HALT;
          else                          w_pc_next    = w_pc_inc;
        end
      end
    endcase
  end

  always_comb begin
    w_fetch_count_next = r_fetch_count;
    if (w_load_fetch && (r_fetch_count != 16'hFFFF))
      w_fetch_count_next = r_fetch_count + 16'd1;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_INIT;
      r_pc          <= 6'd0;
      r_ifid        <= BUBBLE;
      r_fetch_count <= 16'd0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_ifid        <= w_ifid_next;
      r_fetch_count <= w_fetch_count_next;
      r_halted      <= (w_state_next == ST_HALT);
    end
  end

  assign direinstru   = r_pc;
  assign ifid_instru  = r_ifid.instru;
  assign ifid_pc      = r_ifid.pc;
  assign ifid_pc_next = r_ifid.pc_next;
  assign ifid_valid   = r_ifid.valid;
  assign halted       = r_halted;
  assign fetch_count  = r_fetch_count;

endmodule
